bf_loop_ctrl: RTL

Loop-bracket controller for the brainfuck core. It decodes `[` and `]` from the instruction stream and drives the return-address stack with push and pop strobes. It also handles forward skipping of zero-cell loops and issues jump redirects to the fetch unit. It sits between the decode stage and the stack RAM wrapper, and is the only master of that stack.

---
 rtl/bf_loop_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/bf_loop_ctrl.sv
// ----------------------------------------------------------------------------
// bf_loop_ctrl
//
// Loop-bracket controller for the brainfuck core. Decodes '[' and ']' from the
// decode stage, drives the return-address stack (push/pop strobes), skips
// forward over loops whose entry cell is zero, and issues one-cycle jump
// redirects to the fetch unit for loops that repeat.
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   reset         : synchronous, active-low
//   instr_valid   : instruction presented this cycle
//   instr_ready   : controller can accept (low only during the jump cycle)
//   instr         : ASCII opcode; only '[' (0x5B) and ']' (0x5D) are acted on
//   instr_pc      : address of instr
//   cell_zero     : current data cell is zero (used only for brackets in RUN)
//   stack_push    : combinational strobe, write stack_wdata at this edge
//   stack_pop     : combinational strobe, drop the top entry at this edge
//   stack_wdata   : value pushed (always instr_pc)
//   stack_rdata   : current top of stack, reflects the previous edge
//   jump          : registered one-cycle redirect pulse
//   jump_pc       : redirect target, valid while jump is high
//   skipping      : high while skipping a zero-cell loop body
//   depth         : current stack occupancy (0 .. 2^DEPTH_W)
//   err_overflow  : sticky, stack full on push or skip counter saturated
//   err_underflow : sticky, ']' seen with an empty stack
// ----------------------------------------------------------------------------
module bf_loop_ctrl #(
    parameter int PC_W    = 16,
    parameter int DEPTH_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [7:0]         instr,
    input  logic [PC_W-1:0]    instr_pc,
    input  logic               cell_zero,
    output logic               stack_push,
    output logic               stack_pop,
    output logic [PC_W-1:0]    stack_wdata,
    input  logic [PC_W-1:0]    stack_rdata,
    output logic               jump,
    output logic [PC_W-1:0]    jump_pc,
    output logic               skipping,
    output logic [DEPTH_W:0]   depth,
    output logic               err_overflow,
    output logic               err_underflow
);

    localparam logic [7:0]         OP_OPEN  = 8'h5B;
    localparam logic [7:0]         OP_CLOSE = 8'h5D;
    localparam logic [DEPTH_W:0]   CNT_ONE  = (DEPTH_W+1)'(1);
    localparam logic [DEPTH_W:0]   CNT_MAX  = '1;
    localparam logic [PC_W-1:0]    PC_ONE   = PC_W'(1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKIP = 2'd1,
        ST_JUMP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DEPTH_W:0]     depth_q, depth_d;
    logic [DEPTH_W:0]     skip_cnt_q, skip_cnt_d;
    logic [PC_W-1:0]      jump_pc_q, jump_pc_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 err_udf_q, err_udf_d;

    logic accept;
    logic is_open;
    logic is_close;
    logic stack_full;
    logic stack_empty;
    logic skip_last;
    logic skip_sat;

    // Acceptance is decoded straight from the state so it does not depend on
    // the instr_ready output process.
    assign accept      = instr_valid && (state_q != ST_JUMP);
    assign is_open     = (instr == OP_OPEN);
    assign is_close    = (instr == OP_CLOSE);
    // Occupancy never exceeds 2^DEPTH_W, so the top bit alone means full.
    assign stack_full  = depth_q[DEPTH_W];
    assign stack_empty = (depth_q == '0);
    assign skip_last   = (skip_cnt_q == CNT_ONE);
    assign skip_sat    = (skip_cnt_q == CNT_MAX);

    // ------------------------------------------------------------------
    // State register (plus datapath registers sharing the same reset)
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            depth_q    <= '0;
            skip_cnt_q <= '0;
            jump_pc_q  <= '0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            skip_cnt_q <= skip_cnt_d;
            jump_pc_q  <= jump_pc_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && is_open && cell_zero)
                    state_d = ST_SKIP;
                else if (accept && is_close && !cell_zero && !stack_empty)
                    state_d = ST_JUMP;
            end
            ST_SKIP: begin
                if (accept && is_close && skip_last)
                    state_d = ST_RUN;
            end
            ST_JUMP: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready = (state_q != ST_JUMP);
        jump        = (state_q == ST_JUMP);
        skipping    = (state_q == ST_SKIP);
        // Strobes are gated by reset so the stack RAM never moves while the
        // controller is being reset.
        stack_push  = reset && (state_q == ST_RUN) && accept && is_open
                      && !cell_zero && !stack_full;
        stack_pop   = reset && (state_q == ST_RUN) && accept && is_close
                      && cell_zero && !stack_empty;
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        depth_d    = depth_q;
        skip_cnt_d = skip_cnt_q;
        jump_pc_d  = jump_pc_q;
        err_ovf_d  = err_ovf_q;
        err_udf_d  = err_udf_q;

        if (stack_push)
            depth_d = depth_q + CNT_ONE;
        else if (stack_pop)
            depth_d = depth_q - CNT_ONE;

        if (state_q == ST_RUN && accept) begin
            if (is_open) begin
                if (cell_zero)
                    skip_cnt_d = CNT_ONE;
                else if (stack_full)
                    err_ovf_d = 1'b1;
            end else if (is_close) begin
                if (stack_empty)
                    err_udf_d = 1'b1;
                else if (!cell_zero)
                    // Resume at the instruction after the matching '['.
                    jump_pc_d = stack_rdata + PC_ONE;
            end
        end

        if (state_q == ST_SKIP && accept) begin
            if (is_open) begin
                if (skip_sat)
                    err_ovf_d = 1'b1;
                else
                    skip_cnt_d = skip_cnt_q + CNT_ONE;
            end else if (is_close) begin
                // The matching ']' takes the count from 1 to 0 on exit.
                skip_cnt_d = skip_cnt_q - CNT_ONE;
            end
        end
    end

    assign stack_wdata   = instr_pc;
    assign jump_pc       = jump_pc_q;
    assign depth         = depth_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_udf_q;

endmodule
